// File: rtl/dig_readout_if.sv
// Code bus and averaged-result valid/ready channel of dig_readout.
// The slave modport is the reader (dig_readout); master is the driving side.
interface dig_readout_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] code;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             overrun;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;

  modport master (
    output code, out_ready,
    input  out_valid, out_data, out_ovf, overrun, out_min, out_max
  );

  modport slave (
    input  code, out_ready,
    output out_valid, out_data, out_ovf, overrun, out_min, out_max
  );
endinterface

// File: rtl/dig_readout.sv
// Conversion-counter reader: detects end-of-conversion on the code bus and averages
// 2**AVG_LOG2 final counts per result. Optional per-batch min/max: DIG_READOUT_MINMAX_EN.
module dig_readout #(
  parameter int WIDTH    = 5,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  dig_readout_if.slave  bus
);
  localparam int SW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [WIDTH-1:0] CODE_MAX = '1;
  localparam logic [CW-1:0]    LAST_CNT = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] code_q_r;
  logic [SW-1:0]    sum_r;
  logic [SW-1:0]    sum_n;
  logic [SW-1:0]    total_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_n;
  logic             bovf_r;
  logic             bovf_n;
  logic             end_s;
  logic             smp_ovf_s;
  logic [WIDTH-1:0] sample_s;
  logic             done_s;
  logic             load_s;
  logic             res_ovf_s;
  logic [WIDTH-1:0] res_min_s;
  logic [WIDTH-1:0] res_max_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_ovf_r;
  logic             overrun_r;
  logic [WIDTH-1:0] out_min_r;
  logic [WIDTH-1:0] out_max_r;

  // A full-scale count means the counter wrapped; it is kept saturated and flagged.
  assign end_s     = (code_q_r != '0) && (bus.code == '0);
  assign smp_ovf_s = (code_q_r == CODE_MAX);
  assign sample_s  = smp_ovf_s ? CODE_MAX : code_q_r;
  assign res_ovf_s = bovf_r | smp_ovf_s;
  assign load_s    = done_s && (!out_valid_r || bus.out_ready);

  // State, code history and batch accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= SYNC;
      code_q_r <= '0;
      sum_r    <= '0;
      cnt_r    <= '0;
      bovf_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      code_q_r <= bus.code;
      sum_r    <= sum_n;
      cnt_r    <= cnt_n;
      bovf_r   <= bovf_n;
    end
  end

  // Next-state and accumulation: the last sample of a batch completes it on the same edge.
  always_comb begin
    state_n = state_r;
    sum_n   = sum_r;
    cnt_n   = cnt_r;
    bovf_n  = bovf_r;
    done_s  = 1'b0;
    total_s = sum_r + SW'(sample_s);
    case (state_r)
      SYNC: begin
        if (end_s) begin
          state_n = ACC;
        end else begin
          state_n = SYNC;
        end
      end
      ACC: begin
        if (end_s && (cnt_r == LAST_CNT)) begin
          done_s = 1'b1;
          sum_n  = '0;
          cnt_n  = '0;
          bovf_n = 1'b0;
        end else if (end_s) begin
          sum_n  = total_s;
          cnt_n  = cnt_r + CW'(1);
          bovf_n = res_ovf_s;
        end else begin
          state_n = ACC;
        end
      end
      default: begin
        state_n = SYNC;
      end
    endcase
  end

`ifdef DIG_READOUT_MINMAX_EN
  logic [WIDTH-1:0] bmin_r;
  logic [WIDTH-1:0] bmax_r;
  logic             first_s;

  assign first_s = (cnt_r == '0);

  // Running extrema including the current sample; the first sample of a batch restarts them.
  always_comb begin
    res_min_s = bmin_r;
    res_max_s = bmax_r;
    if (first_s || (sample_s < bmin_r)) begin
      res_min_s = sample_s;
    end else begin
      res_min_s = bmin_r;
    end
    if (first_s || (sample_s > bmax_r)) begin
      res_max_s = sample_s;
    end else begin
      res_max_s = bmax_r;
    end
  end

  // Batch extrema registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bmin_r <= '0;
      bmax_r <= '0;
    end else if ((state_r == ACC) && end_s && !done_s) begin
      bmin_r <= res_min_s;
      bmax_r <= res_max_s;
    end else begin
      bmin_r <= bmin_r;
      bmax_r <= bmax_r;
    end
  end
`else
  assign res_min_s = '0;
  assign res_max_s = '0;
`endif

  // Result holding register; a completion that finds it occupied is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
      overrun_r   <= 1'b0;
      out_min_r   <= '0;
      out_max_r   <= '0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= WIDTH'(total_s >> AVG_LOG2);
        out_ovf_r   <= res_ovf_s;
        out_min_r   <= res_min_s;
        out_max_r   <= res_max_s;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (done_s && !load_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.overrun   = overrun_r;
  assign bus.out_min   = out_min_r;
  assign bus.out_max   = out_max_r;
endmodule

// File: tb/tb_dig_readout.sv
// Scoreboard bench for dig_readout: period-level reference model feeds an expectation
// queue, a negedge monitor checks each consumed result. Honours DIG_READOUT_MINMAX_EN.
module tb_dig_readout;
  localparam int WIDTH    = 5;
  localparam int AVG_LOG2 = 2;
  localparam int NAVG     = 1 << AVG_LOG2;
  localparam int FULL     = (1 << WIDTH) - 1;

  typedef struct {
    int data;
    int ovf;
    int mn;
    int mx;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dig_readout_if #(.WIDTH(WIDTH)) bus ();
  dig_readout #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // reference model state (period-level view)
  bit synced;
  int b_sum, b_n, b_min, b_max, b_ovf;
  int last_v;
  int ready_mode;
  int low_run;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    synced = 1'b0;
    b_sum = 0; b_n = 0; b_min = 0; b_max = 0; b_ovf = 0;
  endtask

  // one finished period whose final count was v
  task automatic model_end(input int v);
    exp_t e;
    if (!synced) begin
      synced = 1'b1;
      return;
    end
    if (b_n == 0 || v < b_min) b_min = v;
    if (b_n == 0 || v > b_max) b_max = v;
    b_sum += v;
    if (v == FULL) b_ovf = 1;
    b_n++;
    if (b_n == NAVG) begin
      e.data = b_sum / NAVG;
      e.ovf  = b_ovf;
`ifdef DIG_READOUT_MINMAX_EN
      e.mn = b_min;
      e.mx = b_max;
`else
      e.mn = 0;
      e.mx = 0;
`endif
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      b_sum = 0; b_n = 0; b_ovf = 0;
    end
  endtask

  // present one code sample for one clock
  task automatic drive(input int v);
    bus.code = v[WIDTH-1:0];
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      2: bus.out_ready = 1'b0;
      default: begin
        if (low_run >= 3 || $urandom_range(3, 0) != 0) begin
          bus.out_ready = 1'b1;
          low_run = 0;
        end else begin
          bus.out_ready = 1'b0;
          low_run++;
        end
      end
    endcase
    if (rst) begin
      last_v = 0;
    end else begin
      if (v == 0 && last_v != 0) model_end(last_v);
      last_v = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic period(input int top, input int hold_max);
    for (int v = 0; v <= top; v++) begin
      int reps;
      reps = 1 + $urandom_range(hold_max, 0);
      for (int r = 0; r < reps; r++) drive(v);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      drive(0);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", int'(bus.out_valid), 0);
  endtask

  // monitor: latency on each new result, stability while stalled, data on consume
  logic             prev_valid = 1'b0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_ovf;
  exp_t             mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_hold  <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency_cycle", cyc, exp_q[0].cyc);
      end
      if (bus.out_valid && prev_hold) begin
        check("stall_data_stable", int'(bus.out_data), int'(prev_data));
        check("stall_ovf_stable", int'(bus.out_ovf), int'(prev_ovf));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", int'(bus.out_data), mon_e.data);
          check("out_ovf", int'(bus.out_ovf), mon_e.ovf);
          check("out_min", int'(bus.out_min), mon_e.mn);
          check("out_max", int'(bus.out_max), mon_e.mx);
        end
      end
      prev_valid <= bus.out_valid;
      prev_hold  <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
      prev_ovf   <= bus.out_ovf;
    end
  end

  initial begin
    rst = 1'b1;
    bus.code = '0;
    bus.out_ready = 1'b1;
    ready_mode = 0;
    low_run = 0;
    last_v = 0;
    model_reset();

    // reset state
    drive(0);
    drive(0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_ovf", int'(bus.out_ovf), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_min", int'(bus.out_min), 0);
    check("rst_max", int'(bus.out_max), 0);
    rst = 1'b0;
    repeat (20) drive(0);
    check("idle_valid", int'(bus.out_valid), 0);

    // steady ramp 0..9: one discarded period then one batch
    repeat (5) period(9, 0);
    drive(0);
    wait_drain();

    // ends at 3,5,7,9 with a long constant code inside the 7 period
    period(3, 0);
    period(5, 0);
    for (int v = 0; v < 7; v++) drive(v);
    repeat (20) drive(7);
    period(9, 0);
    drive(0);
    wait_drain();

    // one wrapping period among 8s
    period(FULL, 0);
    repeat (3) period(8, 0);
    drive(0);
    wait_drain();

    // randomized periods, holds and backpressure
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int top;
      top = ($urandom_range(7, 0) == 0) ? FULL : $urandom_range(FULL - 1, 1);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(6, 1)) drive(0);
      period(top, 2);
    end
    drive(0);
    wait_drain();
    ready_mode = 0;

    // reset after two samples of a batch
    period(4, 0);
    period(6, 0);
    drive(0);
    model_reset();
    rst = 1'b1;
    drive(0);
    drive(0);
    rst = 1'b0;
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_data", int'(bus.out_data), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    period(10, 0);
    period(1, 0);
    period(2, 0);
    period(3, 0);
    period(4, 0);
    drive(0);
    wait_drain();

    // backpressure across two batches: second one is dropped
    ready_mode = 2;
    check("pre_overrun", int'(bus.overrun), 0);
    for (int k = 1; k <= 8; k++) period(2 * k, 0);
    drive(0);
    if (exp_q.size() == 2) void'(exp_q.pop_back());
    else check("model_batches", exp_q.size(), 2);
    drive(0);
    drive(0);
    check("held_valid", int'(bus.out_valid), 1);
    if (exp_q.size() > 0) check("held_data", int'(bus.out_data), exp_q[0].data);
    else check("held_queue", exp_q.size(), 1);
    check("overrun_set", int'(bus.overrun), 1);
    ready_mode = 0;
    drive(0);
    check("after_consume_valid", int'(bus.out_valid), 0);
    check("overrun_sticky", int'(bus.overrun), 1);
    repeat (5) drive(0);
    check("overrun_sticky_late", int'(bus.overrun), 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
